// File: rtl/pipe_pkg.sv
// Shared types and constants for the parametrised pipeline stage latch.
package pipe_pkg;

    // Buffer occupancy state; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    // EX/MEM control bundle bit positions.
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;

    // EX/MEM bundle widths: 4 control bits; ALU result 32 + write data 32 + rd 5.
    localparam int CTRL_W_EXMEM = 4;
    localparam int DATA_W_EXMEM = 69;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffered pipeline entry: a control register and a data register with
// load, control clear and data clear. Load takes priority over the clears.
module pipe_entry_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 69
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clr_ctrl_i,
    input  logic              clr_data_i,
    input  logic [CTRL_W-1:0] d_ctrl_i,
    input  logic [DATA_W-1:0] d_data_i,
    output logic [CTRL_W-1:0] q_ctrl_o,
    output logic [DATA_W-1:0] q_data_o
);

    // Entry storage; active-low synchronous reset clears both halves.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            q_ctrl_o <= '0;
            q_data_o <= '0;
        end else if (load_i) begin
            q_ctrl_o <= d_ctrl_i;
            q_data_o <= d_data_i;
        end else begin
            if (clr_ctrl_i) q_ctrl_o <= '0;
            if (clr_data_i) q_data_o <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage latch with valid/ready handshake and a 2-entry skid buffer.
// in_ready_o depends only on registered state and local controls, never on
// out_ready_i, so backpressure does not form a combinational path upstream.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W         = CTRL_W_EXMEM,
    parameter int DATA_W         = DATA_W_EXMEM,
    parameter bit FLUSH_CLR_DATA = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    buf_state_e        state;
    logic              in_fire;
    logic              out_fire;
    logic              do_flush;
    logic              main_load;
    logic              main_clr_ctrl;
    logic              skid_load;
    logic              clr_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;

    assign in_ready_o  = start_i & rst_i & ~flush_i & (state != TWO);
    assign out_valid_o = start_i & (state != EMPTY);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;
    assign do_flush    = start_i & flush_i;
    assign clr_data    = do_flush & FLUSH_CLR_DATA;

    // Main refills from the skid entry when draining TWO, otherwise from input.
    assign main_d_ctrl = (state == TWO) ? skid_ctrl : in_ctrl_i;
    assign main_d_data = (state == TWO) ? skid_data : in_data_i;

    assign main_load = ~do_flush &
                       (((state == EMPTY) & in_fire) |
                        ((state == ONE)   & in_fire & out_fire) |
                        ((state == TWO)   & out_fire));
    assign skid_load = ~do_flush & (state == ONE) & in_fire & ~out_fire;
    assign main_clr_ctrl = do_flush | ((state == ONE) & ~in_fire & out_fire);

    assign out_ctrl_o = out_valid_o ? main_ctrl : '0;
    assign out_data_o = main_data;
    assign count_o    = state;

    // Occupancy FSM: reset beats flush, flush beats handshakes, start_i low freezes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= EMPTY;
        end else if (do_flush) begin
            state <= EMPTY;
        end else if (start_i) begin
            case (state)
                EMPTY: if (in_fire) state <= ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state <= TWO;
                    else if (!in_fire && out_fire) state <= EMPTY;
                end
                TWO:   if (out_fire) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (main_load),
        .clr_ctrl_i (main_clr_ctrl),
        .clr_data_i (clr_data),
        .d_ctrl_i   (main_d_ctrl),
        .d_data_i   (main_d_data),
        .q_ctrl_o   (main_ctrl),
        .q_data_o   (main_data)
    );

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (skid_load),
        .clr_ctrl_i (do_flush),
        .clr_data_i (clr_data),
        .d_ctrl_i   (in_ctrl_i),
        .d_data_i   (in_data_i),
        .q_ctrl_o   (skid_ctrl),
        .q_data_o   (skid_data)
    );

endmodule
